spfa_sched_ctrl: RTL and testbench

//   Work-list scheduler for the SPFA shortest-path datapath. Owns the FIFO of pending vertices and the in-queue bitmap.
//   It issues one vertex at a time to the edge-relaxation datapath and enqueues the vertices that the datapath reports as improved.
//   It signals completion when the work list drains, or aborts when a pop-count limit is hit (negative cycle / runaway).

---
 rtl/spfa_pkg.sv | 20 ++
 rtl/spfa_vq.sv | 66 ++++++
 rtl/spfa_sched_ctrl.sv | 140 ++++++++++++++
 tb/tb_spfa_sched_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/spfa_pkg.sv
// Shared constants and FSM encodings for the SPFA work-list scheduler.
// States are plain localparams so legacy blocks can decode them as bits.
package spfa_pkg;

  localparam int NODE_W     = 4;
  localparam int NODES      = 16;
  localparam int CNT_W      = 9;
  localparam int ITER_LIMIT = 256;

  typedef logic [2:0] state_t;

  localparam state_t IDLE    = 3'd0;
  localparam state_t INIT    = 3'd1;
  localparam state_t POP     = 3'd2;
  localparam state_t ISSUE   = 3'd3;
  localparam state_t SCAN    = 3'd4;
  localparam state_t FINISH  = 3'd5;
  localparam state_t ABORT_S = 3'd6;

endpackage

// File: rtl/spfa_vq.sv
// Circular vertex FIFO; depth is a power of two so pointers wrap freely.
// Simultaneous push and pop leave the occupancy count unchanged.
module spfa_vq #(
  parameter int W     = 4,
  parameter int DEPTH = 16
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] push_id,
  input  logic         pop,
  output logic [W-1:0] head_id,
  output logic [W:0]   count
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rd_ptr;
  logic [W-1:0] wr_ptr;
  logic         empty;
  logic         full;
  logic         do_pop;
  logic         ovf;

  assign empty   = (count == '0);
  assign full    = (count == (W+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign head_id = mem[rd_ptr];
  assign ovf     = push && full && !do_pop;

  always_ff @(posedge CLK) begin
    if (push)
      mem[wr_ptr] <= push_id;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifndef SYNTHESIS
  // The in-queue bitmap should make this unreachable.
  always @(posedge CLK) begin
    if (!RESET)
      assert (!ovf) else $error("spfa_vq overflow");
  end
`endif

endmodule

// File: rtl/spfa_sched_ctrl.sv
// SPFA work-list scheduler: FIFO of pending vertices plus in-queue bitmap,
// issuing one vertex at a time to the relaxation datapath.
module spfa_sched_ctrl
  import spfa_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [NODE_W-1:0] SRC,
  output logic              NODE_VALID,
  output logic [NODE_W-1:0] NODE_ID,
  input  logic              NODE_READY,
  input  logic              SCAN_DONE,
  input  logic              UPD_VALID,
  input  logic [NODE_W-1:0] UPD_ID,
  output logic              BUSY,
  output logic              DONE,
  output logic              ABORT,
  output logic [CNT_W-1:0]  POP_CNT
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(ITER_LIMIT);

  state_t             state;
  logic [NODE_W-1:0]  src_q;
  logic [NODES-1:0]   inq;
  logic               upd_ok;
  logic               q_clr;
  logic               q_push;
  logic               q_pop;
  logic [NODE_W-1:0]  q_din;
  logic [NODE_W-1:0]  q_head;
  logic [NODE_W:0]    q_count;
  logic               q_empty;

  assign q_empty = (q_count == '0);

  always_comb begin
    upd_ok = 1'b0;
    q_clr  = 1'b0;
    q_push = 1'b0;
    q_pop  = 1'b0;
    q_din  = UPD_ID;
    if ((state == ISSUE) || (state == SCAN))
      upd_ok = UPD_VALID && !inq[UPD_ID];
    q_clr = (state == IDLE) && START;
    if (state == INIT) begin
      q_push = 1'b1;
      q_din  = src_q;
    end else begin
      q_push = upd_ok;
    end
    q_pop = (state == POP) && !q_empty
         && (POP_CNT != LIMIT);
  end

  spfa_vq #(
    .W     (NODE_W),
    .DEPTH (NODES)
  ) u_vq (
    .CLK     (CLK),
    .RESET   (RESET),
    .clr     (q_clr),
    .push    (q_push),
    .push_id (q_din),
    .pop     (q_pop),
    .head_id (q_head),
    .count   (q_count)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      src_q      <= '0;
      inq        <= '0;
      NODE_VALID <= 1'b0;
      NODE_ID    <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      ABORT      <= 1'b0;
      POP_CNT    <= '0;
    end else begin
      DONE  <= 1'b0;
      ABORT <= 1'b0;
      if (upd_ok)
        inq[UPD_ID] <= 1'b1;
      case (state)
        IDLE: begin
          if (START) begin
            src_q   <= SRC;
            POP_CNT <= '0;
            inq     <= '0;
            BUSY    <= 1'b1;
            state   <= INIT;
          end
        end
        INIT: begin
          inq[src_q] <= 1'b1;
          state      <= POP;
        end
        POP: begin
          if (q_empty) begin
            DONE  <= 1'b1;
            state <= FINISH;
          end else if (POP_CNT == LIMIT) begin
            ABORT <= 1'b1;
            state <= ABORT_S;
          end else begin
            NODE_ID     <= q_head;
            inq[q_head] <= 1'b0;
            POP_CNT     <= POP_CNT + 1'b1;
            state       <= ISSUE;
          end
        end
        // First ISSUE cycle raises VALID; the handshake completes after.
        ISSUE: begin
          if (!NODE_VALID) begin
            NODE_VALID <= 1'b1;
          end else if (NODE_READY) begin
            NODE_VALID <= 1'b0;
            state      <= SCAN;
          end
        end
        SCAN: begin
          if (SCAN_DONE)
            state <= POP;
        end
        FINISH, ABORT_S: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spfa_sched_ctrl.sv
// Directed bench for spfa_sched_ctrl: the bench plays the relaxation
// datapath and checks pop order, pulses, counters and reset behaviour.
module tb_spfa_sched_ctrl;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       START;
  logic [3:0] SRC;
  logic       NODE_VALID;
  logic [3:0] NODE_ID;
  logic       NODE_READY;
  logic       SCAN_DONE;
  logic       UPD_VALID;
  logic [3:0] UPD_ID;
  logic       BUSY;
  logic       DONE;
  logic       ABORT;
  logic [8:0] POP_CNT;

  int total = 0;
  int bad   = 0;
  logic [3:0] upd_q [$];

  spfa_sched_ctrl dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .START      (START),
    .SRC        (SRC),
    .NODE_VALID (NODE_VALID),
    .NODE_ID    (NODE_ID),
    .NODE_READY (NODE_READY),
    .SCAN_DONE  (SCAN_DONE),
    .UPD_VALID  (UPD_VALID),
    .UPD_ID     (UPD_ID),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .ABORT      (ABORT),
    .POP_CNT    (POP_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic go(input logic [3:0] s);
    START = 1'b1;
    SRC   = s;
    tick();
    START = 1'b0;
  endtask

  task automatic wait_valid;
    int n = 0;
    while (!NODE_VALID && n < 40) begin
      tick();
      n++;
    end
    chk("issue_seen", NODE_VALID, 1);
  endtask

  // Serve one vertex: accept it, stream upd_q, then SCAN_DONE.
  task automatic scan_one(input logic [3:0] exp, input bit with_done);
    int keep;
    wait_valid();
    chk("node_id", NODE_ID, exp);
    tick();
    chk("vld_drop", NODE_VALID, 0);
    keep = with_done ? 1 : 0;
    while (upd_q.size() > keep) begin
      UPD_VALID = 1'b1;
      UPD_ID    = upd_q.pop_front();
      tick();
    end
    UPD_VALID = 1'b0;
    if (upd_q.size() != 0) begin
      UPD_VALID = 1'b1;
      UPD_ID    = upd_q.pop_front();
    end
    SCAN_DONE = 1'b1;
    tick();
    SCAN_DONE = 1'b0;
    UPD_VALID = 1'b0;
  endtask

  task automatic wait_end(input bit exp_abort, input int exp_cnt);
    int n = 0;
    while (!DONE && !ABORT && n < 40) begin
      tick();
      n++;
    end
    chk("end_pulse", {DONE, ABORT}, exp_abort ? 2'b01 : 2'b10);
    chk("end_excl", NODE_VALID, 0);
    chk("end_cnt", POP_CNT, exp_cnt);
    tick();
    chk("pulse_1cyc", {DONE, ABORT}, 0);
    chk("end_idle", BUSY, 0);
  endtask

  initial begin
    RESET      = 1'b1;
    START      = 1'b0;
    SRC        = '0;
    NODE_READY = 1'b1;
    SCAN_DONE  = 1'b0;
    UPD_VALID  = 1'b0;
    UPD_ID     = '0;
    tick();
    tick();
    chk("reset_out",
        {NODE_VALID, NODE_ID, BUSY, DONE, ABORT, POP_CNT}, 0);
    RESET = 1'b0;
    tick();

    // single source, no updates; VALID appears after edge k+3
    go(4'd3);
    chk("busy_k", BUSY, 1);
    chk("lat_k", NODE_VALID, 0);
    tick();
    tick();
    chk("lat_k2", NODE_VALID, 0);
    tick();
    chk("lat_k3", NODE_VALID, 1);
    scan_one(4'd3, 1'b0);
    wait_end(1'b0, 1);

    // chain 0->1->2->3
    go(4'd0);
    upd_q = '{4'd1};
    scan_one(4'd0, 1'b0);
    upd_q = '{4'd2};
    scan_one(4'd1, 1'b0);
    upd_q = '{4'd3};
    scan_one(4'd2, 1'b0);
    scan_one(4'd3, 1'b0);
    wait_end(1'b0, 4);

    // duplicates filtered by the bitmap
    go(4'd0);
    upd_q = '{4'd5, 4'd5, 4'd7, 4'd5};
    scan_one(4'd0, 1'b0);
    scan_one(4'd5, 1'b0);
    scan_one(4'd7, 1'b0);
    wait_end(1'b0, 3);

    // self re-enqueue with SCAN_DONE until the pop limit
    go(4'd4);
    for (int i = 0; i < 256; i++) begin
      upd_q = '{4'd4};
      scan_one(4'd4, 1'b1);
    end
    wait_end(1'b1, 256);
    tick();
    tick();
    chk("cnt_hold", POP_CNT, 256);
    chk("no_done", {DONE, ABORT}, 0);

    // stalled datapath; a second START mid-run is ignored
    NODE_READY = 1'b0;
    go(4'd9);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      START = (i == 3);
      SRC   = 4'd2;
      tick();
      chk("hold", {NODE_VALID, NODE_ID}, {1'b1, 4'd9});
    end
    START      = 1'b0;
    NODE_READY = 1'b1;
    scan_one(4'd9, 1'b0);
    wait_end(1'b0, 1);
    tick();
    tick();
    chk("start_ignored", BUSY, 0);

    // reset in SCAN with 6 queued, then a clean run
    go(4'd1);
    wait_valid();
    tick();
    UPD_VALID = 1'b1;
    UPD_ID    = 4'd6;
    tick();
    UPD_VALID = 1'b0;
    tick();
    chk("pre_rst_cnt", POP_CNT, 1);
    #2;
    RESET = 1'b1;
    #1;
    chk("async_rst",
        {NODE_VALID, NODE_ID, BUSY, DONE, ABORT, POP_CNT}, 0);
    #1;
    RESET = 1'b0;
    tick();
    go(4'd2);
    scan_one(4'd2, 1'b0);
    wait_end(1'b0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
